// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment display scanner with shadow-registered digit data,
// leading-zero suppression and selectable segment/anode polarity.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_TC   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_ON    = (ACTIVE_LOW_SEG != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_NONE  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;

    logic                    terminal;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    lz_blank;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [6:0]              seg_next;

    // Glyph table stored in active-low form; inverted below for active-high panels.
    function automatic logic [6:0] glyph_low(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h18;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign terminal = (cnt_q == CNT_TC);
    assign wrap     = terminal && (idx_q == IDX_LAST);

    // Walk from the most significant digit down so zero_above reflects nibbles i..N-1.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        lz_blank   = 1'b0;
        zero_above = 1'b1;
        an_sel     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (data_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = data_q[4*i +: 4];
                cur_dp    = dp_q[i];
                an_sel[i] = 1'b1;
                lz_blank  = blank_lz && zero_above && (i > 0);
            end
        end
    end

    always_comb begin
        seg_next = SEG_OFF;
        if (enable && !lz_blank) begin
            seg_next = (ACTIVE_LOW_SEG != 0) ? glyph_low(cur_nib) : ~glyph_low(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            dp_q       <= '0;
            frame_done <= 1'b0;
            seg_out    <= SEG_OFF;
            dp_out     <= ~DP_ON;
            an_out     <= AN_NONE;
        end else begin
            cnt_q <= terminal ? '0 : cnt_q + 1'b1;
            if (terminal) begin
                idx_q <= wrap ? '0 : idx_q + 1'b1;
            end
            if (load) begin
                data_q <= data_in;
                dp_q   <= dp_in;
            end
            frame_done <= wrap;
            seg_out    <= seg_next;
            dp_out     <= (enable && cur_dp) ? DP_ON : ~DP_ON;
            if (!enable) begin
                an_out <= AN_NONE;
            end else begin
                an_out <= (ACTIVE_LOW_AN != 0) ? ~an_sel : an_sel;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: cycle-level reference model plus directed literal windows.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          t_model = 0;
    logic [15:0] sh_data = 16'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_fd = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(RD),
        .ACTIVE_LOW_SEG(1),
        .ACTIVE_LOW_AN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .data_in(data_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .enable(enable),
        .seg_out(seg_out),
        .dp_out(dp_out),
        .an_out(an_out),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: position in time since reset determines digit; shadow tracks loads.
    always @(posedge clk or negedge rst_n) begin : model
        int         idx;
        logic [1:0] idx2;
        logic [3:0] nib;
        logic [15:0] upper;
        if (!rst_n) begin
            t_model = 0;
            sh_data = 16'h0;
            sh_dp   = 4'h0;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_an  = 4'hF;
            exp_fd  = 1'b0;
        end else begin
            idx   = (t_model / RD) % N;
            idx2  = 2'(idx);
            upper = sh_data >> (4 * idx);
            nib   = upper[3:0];
            if (!enable || (blank_lz && idx > 0 && upper == 16'h0))
                exp_seg = 7'h7F;
            else
                exp_seg = glyph[nib];
            exp_dp = (enable && sh_dp[idx2]) ? 1'b0 : 1'b1;
            exp_an = enable ? ~(4'b0001 << idx) : 4'hF;
            exp_fd = ((t_model % FRAME) == FRAME - 1);
            if (load) begin
                sh_data = data_in;
                sh_dp   = dp_in;
            end
            t_model++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", 32'(seg_out), 32'(exp_seg));
            check("model_dp", 32'(dp_out), 32'(exp_dp));
            check("model_an", 32'(an_out), 32'(exp_an));
            check("model_fd", 32'(frame_done), 32'(exp_fd));
        end
    end

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic blz);
        data_in  = d;
        dp_in    = dp;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Align to the negedge showing digit 0 of a frame, then check 16 cycles literally.
    task automatic window(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
        int guard = 0;
        logic [6:0] s [4];
        logic [3:0] ea;
        logic       ed;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        repeat (2) @(negedge clk);
        while ((t_model % FRAME) != 1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_align"}, 32'(guard < 40), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            ea = ~(4'b0001 << (k / RD));
            ed = ~dpm[k / RD];
            check({tag, "_seg"}, 32'(seg_out), 32'(s[k / RD]));
            check({tag, "_an"}, 32'(an_out), 32'(ea));
            check({tag, "_dp"}, 32'(dp_out), 32'(ed));
            check({tag, "_fd"}, 32'(frame_done), 32'(k == FRAME - 1));
            @(negedge clk);
        end
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_async_seg"}, 32'(seg_out), 32'h7F);
        check({tag, "_async_an"}, 32'(an_out), 32'hF);
        check({tag, "_async_dp"}, 32'(dp_out), 32'd1);
        check({tag, "_async_fd"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_count;
        int guard;
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_seg", 32'(seg_out), 32'h40);
        check("first_an", 32'(an_out), 32'hE);

        load_word(16'h1234, 4'h0, 1'b0);
        window("scan1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'h0);

        load_word(16'h000F, 4'h0, 1'b1);
        window("lz000f", 7'h0E, 7'h7F, 7'h7F, 7'h7F, 4'h0);
        load_word(16'h0000, 4'h0, 1'b1);
        window("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'h0);

        load_word(16'h0005, 4'b0100, 1'b1);
        window("dp0005", 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0100);

        enable = 1'b0;
        @(negedge clk);
        fd_count = 0;
        for (int i = 0; i < 20; i++) begin
            check("dis_seg", 32'(seg_out), 32'h7F);
            check("dis_dp", 32'(dp_out), 32'd1);
            check("dis_an", 32'(an_out), 32'hF);
            fd_count += int'(frame_done);
            @(negedge clk);
        end
        check("dis_fd_seen", 32'(fd_count >= 1), 32'd1);
        enable = 1'b1;
        repeat (6) @(negedge clk);

        guard = 0;
        load_word(16'h0000, 4'h0, 1'b0);
        while ((t_model % FRAME) != 3 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("tc_align", 32'(guard < 40), 32'd1);
        data_in = 16'hABCD;
        dp_in   = 4'h0;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        check("tc_load_an", 32'(an_out), 32'hD);
        check("tc_load_seg", 32'(seg_out), 32'h46);

        repeat (5) @(negedge clk);
        reset_pulse("midrst");
        @(negedge clk);
        check("midrst_seg", 32'(seg_out), 32'h40);
        check("midrst_an", 32'(an_out), 32'hE);

        for (int c = 0; c < 1500; c++) begin
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom) & masks[$urandom_range(0, 4)];
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse("rnd");
            end else begin
                @(negedge clk);
            end
        end
        load = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
